// File: rtl/countdown_commander.sv
// Operator front end for the countdown controller: debounced push-buttons, clamped duration
// latch, start / end_timer handshakes with timeout, and run-outcome reporting.

module countdown_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic             level;
   logic [CNT_W-1:0] stable_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would collapse the synchronizer into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1    <= 1'b0;
         sync_q2    <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
         press   <= 1'b0;
         if (sync_q2 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            // Enough consecutive differing samples: accept the new level, pulse on rise only.
            level      <= sync_q2;
            stable_cnt <= '0;
            press      <= sync_q2;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

module countdown_commander #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned SEC_COUNT       = 100_000_000,
   parameter int unsigned MAX_TIME        = 15,
   parameter int unsigned HS_TIMEOUT      = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic [7:0] sw_time,
   input  logic       counting,
   input  logic       done,
   output logic       start,
   output logic       end_timer,
   output logic [7:0] countdown_time,
   output logic [2:0] state_out,
   output logic       timeout_flag,
   output logic       stopped_flag,
   output logic       hs_error,
   output logic [7:0] elapsed_sec
);

   localparam int unsigned SEC_W = (SEC_COUNT > 1) ? $clog2(SEC_COUNT) : 1;
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_COUNT - 1);
   localparam int unsigned HS_W = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
   localparam logic [HS_W-1:0] HS_LAST = HS_W'(HS_TIMEOUT - 1);
   localparam logic [7:0] MAX_T = 8'(MAX_TIME);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LAUNCH   = 3'd1,
      S_RUNNING  = 3'd2,
      S_STOPPING = 3'd3,
      S_RESULT   = 3'd4
   } state_t;

   state_t           state;
   logic             start_press;
   logic             stop_press;
   logic [7:0]       clamped_time;
   logic [SEC_W-1:0] sec_cnt;
   logic [HS_W-1:0]  hs_cnt;

   countdown_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_start),
      .press (start_press)
   );

   countdown_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_stop),
      .press (stop_press)
   );

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      clamped_time = sw_time;
      if (sw_time > MAX_T) clamped_time = MAX_T;
   end

   assign state_out = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         start          <= 1'b0;
         end_timer      <= 1'b0;
         countdown_time <= '0;
         timeout_flag   <= 1'b0;
         stopped_flag   <= 1'b0;
         hs_error       <= 1'b0;
         elapsed_sec    <= '0;
         sec_cnt        <= '0;
         hs_cnt         <= '0;
      end else begin
         case (state)
            S_IDLE, S_RESULT: begin
               // Start outranks a simultaneous stop here; stop only matters from RESULT.
               if (start_press) begin
                  countdown_time <= clamped_time;
                  timeout_flag   <= 1'b0;
                  stopped_flag   <= 1'b0;
                  hs_error       <= 1'b0;
                  elapsed_sec    <= '0;
                  sec_cnt        <= '0;
                  hs_cnt         <= '0;
                  start          <= 1'b1;
                  state          <= S_LAUNCH;
               end else if (state == S_RESULT && stop_press) begin
                  timeout_flag <= 1'b0;
                  stopped_flag <= 1'b0;
                  hs_error     <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            S_LAUNCH: begin
               if (counting) begin
                  start <= 1'b0;
                  state <= S_RUNNING;
               end else if (hs_cnt == HS_LAST) begin
                  start    <= 1'b0;
                  hs_error <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  hs_cnt <= hs_cnt + 1'b1;
               end
            end

            S_RUNNING: begin
               if (sec_cnt == SEC_LAST) begin
                  sec_cnt <= '0;
                  if (elapsed_sec != 8'hFF) elapsed_sec <= elapsed_sec + 1'b1;
               end else begin
                  sec_cnt <= sec_cnt + 1'b1;
               end

               if (done) begin
                  timeout_flag <= 1'b1;
                  state        <= S_RESULT;
               end else if (!counting) begin
                  // Controller dropped out without signalling expiry.
                  hs_error <= 1'b1;
                  state    <= S_RESULT;
               end else if (stop_press) begin
                  end_timer <= 1'b1;
                  hs_cnt    <= '0;
                  state     <= S_STOPPING;
               end
            end

            S_STOPPING: begin
               if (done) begin
                  // Natural expiry beat the stop request.
                  end_timer    <= 1'b0;
                  timeout_flag <= 1'b1;
                  state        <= S_RESULT;
               end else if (!counting) begin
                  end_timer    <= 1'b0;
                  stopped_flag <= 1'b1;
                  state        <= S_RESULT;
               end else if (hs_cnt == HS_LAST) begin
                  end_timer <= 1'b0;
                  hs_error  <= 1'b1;
                  state     <= S_RESULT;
               end else begin
                  hs_cnt <= hs_cnt + 1'b1;
               end
            end

            default: begin
               start     <= 1'b0;
               end_timer <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   a_req_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(start && end_timer));
   a_flag_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(timeout_flag && stopped_flag));

endmodule
